icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache between the fetch unit and unified main memory.
//  Returns the 16-bit instruction word on a hit in the same cycle. On a miss, refills a whole
//  line one word per memory beat, then replays the request. Exports saturating hit/miss
//  counters for the perf monitor and the top-level bench.
// PARAMETERS
//  INDEX_BITS  4   log2(number of lines); default 16 lines
//  LINE_WORDS  4   16-bit words per line; power of 2, >=2; OFF_BITS=$clog2(LINE_WORDS)
//  CNT_W       32  width of hit/miss counters
// PORTS
//  clk            in   1      system clock, all state on posedge
//  rst            in   1      synchronous, active-high reset
//  cpu_req_valid  in   1      fetch request; held with stable addr until cpu_res_ready
//  cpu_req_addr   in   16     word address of instruction (PC)
//  cpu_res_ready  out  1      cpu_res_data valid this cycle; request complete
//  cpu_res_data   out  16     instruction word
//  flush          in   1      invalidate all lines (1-cycle pulse)
//  mem_req_valid  out  1      memory read request for mem_req_addr
//  mem_req_addr   out  16     word address of current refill beat
//  mem_res_valid  in   1      mem_res_data valid; completes the current beat
//  mem_res_data   in   16     returned word
//  busy           out  1      high in any state other than IDLE
//  hit_cnt        out  CNT_W  first-attempt hits, saturating
//  miss_cnt       out  CNT_W  misses (refills started), saturating
// BEHAVIOUR
//  - Address split: tag=[15:INDEX_BITS+OFF_BITS], index=[INDEX_BITS+OFF_BITS-1:OFF_BITS],
//    offset=[OFF_BITS-1:0]. Arrays: valid[], tag[], data[][], all flops (async read).
//  - Reset: state=IDLE; all valid=0; beat=0; counters=0; flush_pend=0. Outputs: cpu_res_ready=0,
//    mem_req_valid=0, busy=0, mem_req_addr=0. Data/tag contents are not reset.
//  - hit = cpu_req_valid & valid[index] & (tag[index]==tag).
//  - IDLE:
//    - flush|flush_pend: clear all valid, clear flush_pend, cpu_res_ready=0 this cycle.
//      Flush has priority over a same-cycle request; the request is re-evaluated next cycle.
//    - else hit: cpu_res_ready=1 and cpu_res_data=data[index][offset] combinationally.
//      hit_cnt++ unless the replay flag is set; the replay flag clears.
//    - else valid request, miss: latch line base {tag,index,0}; beat=0; miss_cnt++;
//      go to REFILL.
//  - REFILL:
//    - mem_req_valid=1; mem_req_addr = base + beat.
//    - On mem_res_valid: data[index][beat]=mem_res_data; beat++.
//    - On the last beat (beat==LINE_WORDS-1), go to ALLOC.
//    - mem_res_valid in any other state is ignored.
//  - ALLOC (1 cycle): tag[index]=base tag, valid[index]=1; set replay flag; go to IDLE.
//    IDLE then hits on the held request.
//  - Miss latency: request cycle + LINE_WORDS beats + ALLOC + replay cycle.
//    With 1-cycle memory and LINE_WORDS=4: cpu_res_ready 6 cycles after the miss cycle.
//  - flush asserted in REFILL/ALLOC sets flush_pend. The refill completes; the invalidate is
//    applied in the next IDLE cycle, before the replay, so the replay misses again.
//  - cpu_res_ready is never asserted outside IDLE. The old line's valid stays 0 during REFILL
//    (cleared on miss entry) so no partial line is ever hit.
//  - Counters saturate at all-ones; no wrap.
//  - Reset mid-REFILL: next cycle IDLE, mem_req_valid=0, all lines invalid; stale mem_res_valid
//    is ignored.
//  - Index wrap: addresses differing only in tag evict each other (direct-mapped). beat counter
//    wraps via OFF_BITS width.
// TESTING
//  1 Cold miss:
//    - Stimulus: rst, then req 0x0010; memory (1-cycle) returns 0xA000+addr.
//    - Expect: mem_req_addr 0x0010..0x0013 in order; cpu_res_ready 6 cycles later with
//      data 0xA010; miss_cnt=1, hit_cnt=0.
//  2 Hit:
//    - Stimulus: after test 1, req 0x0012.
//    - Expect: same-cycle cpu_res_ready, data 0xA012; hit_cnt=1; mem_req_valid stays 0.
//  3 Conflict:
//    - Stimulus: req 0x0050 (same index, tag differs from 0x0010), then 0x0010.
//    - Expect: two refills; miss_cnt +2; data 0xA050 then 0xA010.
//  4 Flush:
//    - Stimulus: flush pulse in IDLE together with req 0x0012.
//    - Expect: no response that cycle; next cycle miss; miss_cnt increments.
//    - Stimulus: flush during REFILL beat 2.
//    - Expect: refill completes, then the replay misses again.
//  5 Reset mid-refill:
//    - Stimulus: assert rst at beat 1.
//    - Expect: mem_req_valid=0 and busy=0 next cycle.
//    - Stimulus: a late mem_res_valid, then req to the same line.
//    - Expect: the late response is ignored; the request is a miss; counters read 0 before it.
//  6 Saturation and stall:
//    - Stimulus: force miss_cnt to 2^CNT_W-1, then a miss.
//    - Expect: miss_cnt holds at all-ones.
//    - Stimulus: memory with random 1-5 cycle latency.
//    - Expect: the line is still filled correctly in order.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache with line refill and hit/miss counters
`timescale 1ns/1ps
module icache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_valid,
    input  logic [15:0]      cpu_req_addr,
    output logic             cpu_res_ready,
    output logic [15:0]      cpu_res_data,
    input  logic             flush,
    output logic             mem_req_valid,
    output logic [15:0]      mem_req_addr,
    input  logic             mem_res_valid,
    input  logic [15:0]      mem_res_data,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 16 - INDEX_BITS - OFF_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, ALLOC} state_t;

    state_t                state, state_next;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [15:0]           data [LINES][LINE_WORDS];
    logic [OFF_BITS-1:0]   beat;
    logic [TAG_BITS-1:0]   base_tag;
    logic [INDEX_BITS-1:0] base_index;
    logic                  flush_pend, replay, start_miss;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [OFF_BITS-1:0]   req_off;
    logic                  hit, do_flush;

    assign req_tag      = cpu_req_addr[15:INDEX_BITS+OFF_BITS];
    assign req_index    = cpu_req_addr[INDEX_BITS+OFF_BITS-1:OFF_BITS];
    assign req_off      = cpu_req_addr[OFF_BITS-1:0];
    assign hit          = cpu_req_valid & valid[req_index] & (tags[req_index] == req_tag);
    assign do_flush     = flush | flush_pend;
    assign busy         = state != IDLE;
    assign cpu_res_data = data[req_index][req_off];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and handshake outputs; a pending invalidate beats any request in IDLE
    always_comb begin
        state_next    = state;
        start_miss    = 1'b0;
        cpu_res_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state)
            IDLE: begin
                cpu_res_ready = !do_flush && hit;
                start_miss    = !do_flush && !hit && cpu_req_valid;
                state_next    = start_miss ? REFILL : IDLE;
            end
            REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {base_tag, base_index, beat};
                state_next    = (mem_res_valid && beat == LAST_BEAT) ? ALLOC : REFILL;
            end
            ALLOC:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state: valid bits, refill pointer, flush/replay flags and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            replay     <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            base_tag   <= '0;
            base_index <= '0;
        end else begin
            if (state == IDLE) flush_pend <= 1'b0;
            else if (flush) flush_pend <= 1'b1;
            if (state == IDLE && do_flush) valid <= '0;
            if (cpu_res_ready) begin
                replay <= 1'b0;
                if (!replay && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (start_miss) begin
                base_tag          <= req_tag;
                base_index        <= req_index;
                beat              <= '0;
                valid[req_index]  <= 1'b0;
                replay            <= 1'b0;
                miss_cnt          <= (miss_cnt != '1) ? miss_cnt + CNT_W'(1) : miss_cnt;
            end
            if (state == REFILL && mem_res_valid) beat <= beat + OFF_BITS'(1);
            if (state == ALLOC) begin
                valid[base_index] <= 1'b1;
                replay            <= 1'b1;
            end
        end
    end

    // Tag and data storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_res_valid) data[base_index][beat] <= mem_res_data;
        if (state == ALLOC) tags[base_index] <= base_tag;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed vector bench for icache_ctrl with a latency-programmable memory model
`timescale 1ns/1ps
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst, cpu_req_valid, flush, mem_res_valid;
    logic [15:0] cpu_req_addr, mem_res_data, cpu_res_data, mem_req_addr;
    logic        cpu_res_ready, mem_req_valid, busy;
    logic [31:0] hit_cnt, miss_cnt;
    logic        s_ready, s_mreq, s_busy;
    logic [15:0] s_data, s_maddr;
    logic [1:0]  s_hit, s_miss;

    logic        late = 1'b0, rand_lat = 1'b0;
    int          wait_cnt = 0;
    logic [15:0] beats[$];
    int          errors = 0, checks = 0;
    int          hits_m = 0, misses_m = 0;

    typedef struct {
        logic [15:0] addr;
        int          flush_at;
        bit          rnd;
        logic [15:0] data;
        int          lat;
        int          miss;
        int          hit;
    } vec_t;
    vec_t vecs[15];

    icache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_res_valid(mem_res_valid),
        .mem_res_data(mem_res_data), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_ctrl #(.CNT_W(2)) sat (
        .clk(clk), .rst(rst), .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_res_ready(s_ready), .cpu_res_data(s_data), .flush(flush),
        .mem_req_valid(s_mreq), .mem_req_addr(s_maddr), .mem_res_valid(mem_res_valid),
        .mem_res_data(mem_res_data), .busy(s_busy), .hit_cnt(s_hit), .miss_cnt(s_miss)
    );

    always #5 clk = ~clk;

    assign mem_res_valid = late | (mem_req_valid && wait_cnt == 0);
    assign mem_res_data  = late ? 16'hDEAD : 16'hA000 + mem_req_addr;

    always @(posedge clk) begin
        if (mem_req_valid && mem_res_valid && !rst) beats.push_back(mem_req_addr);
        wait_cnt <= (mem_req_valid && wait_cnt != 0) ? wait_cnt - 1 : (rand_lat ? int'($urandom_range(0, 4)) : 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        int          lat;
        logic [15:0] d;
        bit          ok;
        logic [15:0] base;
        lat  = -1;
        d    = 16'h0;
        ok   = 1'b0;
        base = {v.addr[15:2], 2'b00};
        beats.delete();
        @(negedge clk);
        rand_lat      = v.rnd;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = v.addr;
        for (int c = 0; c < 300; c++) begin
            flush = (c == v.flush_at);
            #1;
            if (cpu_res_ready) begin
                d   = cpu_res_data;
                lat = c;
                ok  = 1'b1;
                check({name, " busy"}, {31'b0, busy}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
        flush         = 1'b0;
        check({name, " ready"}, {31'b0, ok}, 32'd1);
        check({name, " data"}, {16'b0, d}, {16'b0, v.data});
        if (v.lat >= 0) check({name, " latency"}, lat, v.lat);
        check({name, " beats"}, beats.size(), 4 * v.miss);
        foreach (beats[i]) check($sformatf("%s beat%0d", name, i), {16'b0, beats[i]}, {16'b0, base + 16'(i % 4)});
        misses_m += v.miss;
        hits_m   += v.hit;
        check({name, " hit_cnt"}, hit_cnt, hits_m);
        check({name, " miss_cnt"}, miss_cnt, misses_m);
        check({name, " sat hit"}, {30'b0, s_hit}, (hits_m > 3) ? 3 : hits_m);
        check({name, " sat miss"}, {30'b0, s_miss}, (misses_m > 3) ? 3 : misses_m);
    endtask

    initial begin
        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = 16'h0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ready", {31'b0, cpu_res_ready}, 32'd0);
        check("reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset mem_req_addr", {16'b0, mem_req_addr}, 32'd0);
        check("reset hit_cnt", hit_cnt, 32'd0);
        check("reset miss_cnt", miss_cnt, 32'd0);

        vecs[0]  = '{16'h0010, -1, 1'b0, 16'hA010, 6, 1, 0};
        vecs[1]  = '{16'h0012, -1, 1'b0, 16'hA012, 0, 0, 1};
        vecs[2]  = '{16'h0050, -1, 1'b0, 16'hA050, 6, 1, 0};
        vecs[3]  = '{16'h0010, -1, 1'b0, 16'hA010, 6, 1, 0};
        vecs[4]  = '{16'h0013, -1, 1'b0, 16'hA013, 0, 0, 1};
        vecs[5]  = '{16'h0023, -1, 1'b0, 16'hA023, 6, 1, 0};
        vecs[6]  = '{16'h0010, -1, 1'b0, 16'hA010, 0, 0, 1};
        vecs[7]  = '{16'h0012,  0, 1'b0, 16'hA012, 7, 1, 0};
        vecs[8]  = '{16'h0034,  3, 1'b0, 16'hA034, 13, 2, 0};
        vecs[9]  = '{16'h0034, -1, 1'b0, 16'hA034, 0, 0, 1};
        vecs[10] = '{16'h0068, -1, 1'b1, 16'hA068, -1, 1, 0};
        vecs[11] = '{16'h006B, -1, 1'b1, 16'hA06B, 0, 0, 1};
        vecs[12] = '{16'h0069, -1, 1'b1, 16'hA069, 0, 0, 1};
        vecs[13] = '{16'h006A, -1, 1'b1, 16'hA06A, 0, 0, 1};
        vecs[14] = '{16'h0068, -1, 1'b1, 16'hA068, 0, 0, 1};
        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        @(negedge clk);
        rand_lat      = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 16'h0044;
        repeat (2) @(negedge clk);
        #1;
        check("pre-reset beat1 addr", {16'b0, mem_req_addr}, 32'h0045);
        @(negedge clk);
        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("mid-reset busy", {31'b0, busy}, 32'd0);
        check("mid-reset hit_cnt", hit_cnt, 32'd0);
        check("mid-reset miss_cnt", miss_cnt, 32'd0);
        check("mid-reset sat miss", {30'b0, s_miss}, 32'd0);
        @(negedge clk);
        late = 1'b1;
        @(negedge clk);
        late = 1'b0;
        #1;
        check("late resp busy", {31'b0, busy}, 32'd0);
        hits_m   = 0;
        misses_m = 0;
        apply('{16'h0044, -1, 1'b0, 16'hA044, 6, 1, 0}, "post-reset 0044");
        apply('{16'h0010, -1, 1'b0, 16'hA010, 6, 1, 0}, "post-reset 0010");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
